// File: rtl/sram_arbiter.sv
// sram_arbiter
// Shares one SRAM-like request/response bus between the IF-stage fetch
// port and the MEM-stage load/store port. Only one transaction is in flight
// at a time. The arbiter runs the addr_ok/data_ok handshake, returns read
// data to whichever stage won, and asks the stall controller to hold each
// stage until its access completes.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   inst_req/inst_addr    fetch request, held by IF until inst_done
//   inst_rdata/inst_done  fetch data (held until next capture), 1-cycle pulse
//   data_req/data_wr/data_wstrb/data_addr/data_wdata
//                         MEM request, held until data_done
//   data_rdata/data_done  load data (held until next capture), 1-cycle pulse
//   bus_req/bus_wr/bus_wstrb/bus_addr/bus_wdata
//                         request toward the memory slave, fields latched at grant
//   bus_addr_ok/bus_data_ok/bus_rdata
//                         slave handshake and read data
//   stallreq_if/stallreq_mem
//                         per-stage stall requests
module sram_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            inst_req,
    input  logic [AW-1:0]   inst_addr,
    output logic [DW-1:0]   inst_rdata,
    output logic            inst_done,

    input  logic            data_req,
    input  logic            data_wr,
    input  logic [DW/8-1:0] data_wstrb,
    input  logic [AW-1:0]   data_addr,
    input  logic [DW-1:0]   data_wdata,
    output logic [DW-1:0]   data_rdata,
    output logic            data_done,

    output logic            bus_req,
    output logic            bus_wr,
    output logic [DW/8-1:0] bus_wstrb,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    input  logic            bus_addr_ok,
    input  logic            bus_data_ok,
    input  logic [DW-1:0]   bus_rdata,

    output logic            stallreq_if,
    output logic            stallreq_mem
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    // owner_data: the transaction in flight belongs to the MEM stage.
    // last_grant_data: the most recent grant went to the MEM stage.
    logic owner_data;
    logic last_grant_data;
    logic grant_data;
    logic grant_inst;
    logic capture;

    // Data normally wins; when both stages are waiting and data took the
    // previous grant, the fetch goes first so neither stage can starve.
    always_comb begin
        grant_data = data_req & (~inst_req | ~last_grant_data);
        grant_inst = inst_req & ~grant_data;
    end

    // Read data is taken on the data_ok that completes the transaction,
    // either together with addr_ok in ADDR or later in DATA.
    always_comb begin
        capture = bus_data_ok &
                  (((state == ADDR) & bus_addr_ok) | (state == DATA));
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Slave handshakes outside the phase that expects
    // them are simply not looked at.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (inst_req | data_req) begin
                    next_state = ADDR;
                end
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    next_state = bus_data_ok ? DONE : DATA;
                end
            end
            DATA: begin
                if (bus_data_ok) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs decoded from state. Stalls are combinational so a stage is
    // released in the same cycle its done pulse appears.
    always_comb begin
        bus_req      = (state == ADDR);
        inst_done    = (state == DONE) & ~owner_data;
        data_done    = (state == DONE) & owner_data;
        stallreq_if  = inst_req & ~inst_done;
        stallreq_mem = data_req & ~data_done;
    end

    // Request fields are latched once at grant so later changes on the
    // requester side cannot disturb an address phase in progress.
    // A fetch is always a plain read: no write, no byte enables.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_data      <= 1'b0;
            last_grant_data <= 1'b0;
            bus_wr          <= 1'b0;
            bus_wstrb       <= '0;
            bus_addr        <= '0;
            bus_wdata       <= '0;
        end else if (state == IDLE) begin
            if (grant_data) begin
                owner_data      <= 1'b1;
                last_grant_data <= 1'b1;
                bus_wr          <= data_wr;
                bus_wstrb       <= data_wstrb;
                bus_addr        <= data_addr;
                bus_wdata       <= data_wdata;
            end else if (grant_inst) begin
                owner_data      <= 1'b0;
                last_grant_data <= 1'b0;
                bus_wr          <= 1'b0;
                bus_wstrb       <= '0;
                bus_addr        <= inst_addr;
                bus_wdata       <= '0;
            end
        end
    end

    // Read data registers. Stores complete without touching data_rdata,
    // so the last load value stays visible to the MEM stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_rdata <= '0;
            data_rdata <= '0;
        end else if (capture & ~bus_wr) begin
            if (owner_data) begin
                data_rdata <= bus_rdata;
            end else begin
                inst_rdata <= bus_rdata;
            end
        end
    end

endmodule
